// File: rtl/fht_control_param.sv
// Stage/address sequencer for an in-place radix-4 FHT over a 4-bank ping-pong memory.
// Generates direct/reflected read addresses, twiddle index, LAT-delayed write addresses and enables.
module fht_control_param #(
    parameter int A_BIT  = 8,
    parameter int LAT    = 4,
    parameter int ST_BIT = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    input  logic              iSTALL,
    input  logic              iABORT,
    output logic [A_BIT-1:0]  oADDR_RD,
    output logic [A_BIT-1:0]  oADDR_RD_BIAS,
    output logic              oRD_VALID,
    output logic [A_BIT-1:0]  oADDR_COEF,
    output logic [A_BIT-1:0]  oADDR_WR,
    output logic [A_BIT-1:0]  oADDR_WR_BIAS,
    output logic              oWE_A,
    output logic              oWE_B,
    output logic              oSOURCE_DATA,
    output logic [ST_BIT-1:0] oSTAGE,
    output logic              oST_ZERO,
    output logic              oST_LAST,
    output logic              oRDY,
    output logic              oDONE
);

    localparam logic [1:0]        S_IDLE   = 2'd0;
    localparam logic [1:0]        S_READ   = 2'd1;
    localparam logic [1:0]        S_DRAIN  = 2'd2;
    localparam logic [A_BIT-1:0]  J_LAST   = '1;
    localparam logic [ST_BIT-1:0] ST_FINAL = ST_BIT'(A_BIT);
    localparam logic [3:0]        DRN_LAST = 4'(LAT - 1);

    logic [1:0]        state_q, state_nxt;
    logic [ST_BIT-1:0] stage_q, stage_nxt;
    logic [A_BIT-1:0]  j_q, j_nxt;
    logic [3:0]        drn_q, drn_nxt;
    logic [A_BIT-1:0]  bias_q, coef_q;
    logic              done_q, done_nxt;
    logic              abort_take;

    logic [A_BIT-1:0]  wr_j_p    [LAT];
    logic [A_BIT-1:0]  wr_bias_p [LAT];
    logic              vld_p     [LAT];
    logic              odd_p     [LAT];

    // Low s bits set: the span-2^s butterfly group mask (all ones at the last stage).
    function automatic logic [A_BIT-1:0] span_mask(input logic [ST_BIT-1:0] s);
        logic [A_BIT:0] one_hot;
        one_hot = (A_BIT+1)'(1) << s;
        return A_BIT'(one_hot - (A_BIT+1)'(1));
    endfunction

    // Hartley reflection inside the group; stage 0 degenerates to bias = j.
    function automatic logic [A_BIT-1:0] bias_of(input logic [A_BIT-1:0] j,
                                                 input logic [ST_BIT-1:0] s);
        logic [A_BIT-1:0] mask;
        logic [A_BIT-1:0] m;
        mask = span_mask(s);
        m    = j & mask;
        return (j & ~mask) | ((A_BIT'(0) - m) & mask);
    endfunction

    function automatic logic [A_BIT-1:0] coef_of(input logic [A_BIT-1:0] j,
                                                 input logic [ST_BIT-1:0] s);
        logic [A_BIT-1:0] m;
        m = j & span_mask(s);
        return m << (ST_FINAL - s);
    endfunction

    assign abort_take = iABORT && (state_q != S_IDLE);

    always_comb begin
        state_nxt = state_q;
        stage_nxt = stage_q;
        j_nxt     = j_q;
        drn_nxt   = drn_q;
        done_nxt  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_nxt = S_READ;
                    stage_nxt = '0;
                    j_nxt     = '0;
                end
            end
            S_READ: begin
                if (j_q == J_LAST) begin
                    state_nxt = S_DRAIN;
                    drn_nxt   = '0;
                end else begin
                    j_nxt = j_q + A_BIT'(1);
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    if (stage_q == ST_FINAL) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_READ;
                        stage_nxt = stage_q + ST_BIT'(1);
                        j_nxt     = '0;
                    end
                end else begin
                    drn_nxt = drn_q + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // p0: read-side state, addresses registered from next-state values
    always_ff @(posedge iCLK) begin
        if (iRESET || abort_take) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drn_q   <= '0;
            bias_q  <= '0;
            coef_q  <= '0;
            done_q  <= 1'b0;
        end else if (iSTALL) begin
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            stage_q <= stage_nxt;
            j_q     <= j_nxt;
            drn_q   <= drn_nxt;
            bias_q  <= bias_of(j_nxt, stage_nxt);
            coef_q  <= coef_of(j_nxt, stage_nxt);
            done_q  <= done_nxt;
        end
    end

    // p1..pLAT: write delay line; carries the read-time stage parity for bank routing
    always_ff @(posedge iCLK) begin
        if (iRESET || abort_take) begin
            for (int i = 0; i < LAT; i++) begin
                wr_j_p[i]    <= '0;
                wr_bias_p[i] <= '0;
                vld_p[i]     <= 1'b0;
                odd_p[i]     <= 1'b0;
            end
        end else if (!iSTALL) begin
            wr_j_p[0]    <= j_q;
            wr_bias_p[0] <= bias_q;
            vld_p[0]     <= (state_q == S_READ);
            odd_p[0]     <= stage_q[0];
            for (int i = 1; i < LAT; i++) begin
                wr_j_p[i]    <= wr_j_p[i-1];
                wr_bias_p[i] <= wr_bias_p[i-1];
                vld_p[i]     <= vld_p[i-1];
                odd_p[i]     <= odd_p[i-1];
            end
        end
    end

    assign oADDR_RD      = j_q;
    assign oADDR_RD_BIAS = bias_q;
    assign oADDR_COEF    = coef_q;
    assign oRD_VALID     = (state_q == S_READ) && !iSTALL;
    assign oADDR_WR      = wr_j_p[LAT-1];
    assign oADDR_WR_BIAS = wr_bias_p[LAT-1];
    assign oWE_B         = vld_p[LAT-1] && !odd_p[LAT-1] && !iSTALL;
    assign oWE_A         = vld_p[LAT-1] &&  odd_p[LAT-1] && !iSTALL;
    assign oSOURCE_DATA  = stage_q[0];
    assign oSTAGE        = stage_q;
    assign oST_ZERO      = (stage_q == '0);
    assign oST_LAST      = (stage_q == ST_FINAL);
    assign oRDY          = (state_q == S_IDLE);
    assign oDONE         = done_q;

endmodule

// File: doc/fht_control_param.md
# fht_control_param

Parametrised successor of the FHT stage/address controller. It sequences an in-place radix-4 Fast Hartley Transform over a 4-bank ping-pong memory, generating per-stage read addresses (direct and Hartley-reflected), the coefficient index, the pipeline-delayed write addresses, write enables and the buffer-select signal. Over the fixed-size controller it adds generic depth and datapath latency, stall/abort control, a read-valid strobe and a done pulse. It sits between the top-level FHT sequencer and the butterfly datapath/RAM banks.

## Interface
- A_BIT, 8: per-bank address width; bank depth D = 2^A_BIT; stage count STAGES = A_BIT+1
- LAT, 4: butterfly datapath latency from read address to write address, cycles, 1..15
- ST_BIT, 4: stage counter width, must hold A_BIT
- iCLK  in  1  clock
- iRESET  in  1  synchronous, active-high reset
- iSTART  in  1  start request, sampled only while oRDY=1
- iSTALL  in  1  freeze whole controller, including write delay line
- iABORT  in  1  terminate transform, return to IDLE
- oADDR_RD  out  A_BIT  direct read address j (banks 0, 2)
- oADDR_RD_BIAS  out  A_BIT  reflected read address (banks 1, 3)
- oRD_VALID  out  1  read addresses valid this cycle
- oADDR_COEF  out  A_BIT  twiddle table index
- oADDR_WR  out  A_BIT  oADDR_RD delayed LAT active cycles
- oADDR_WR_BIAS  out  A_BIT  oADDR_RD_BIAS delayed LAT active cycles
- oWE_A / oWE_B  out  1  write enable, buffer A / buffer B
- oSOURCE_DATA  out  1  read buffer select: 0=A, 1=B (= stage[0])
- oSTAGE  out  ST_BIT  current stage
- oST_ZERO / oST_LAST  out  1  stage==0 / stage==A_BIT
- oRDY  out  1  idle, ready for iSTART
- oDONE  out  1  one-cycle pulse on normal completion

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: oRDY=1. iSTART=1 -> READ, stage=0, j=0.
- READ: oRD_VALID=1, j increments each unstalled cycle; at j=D-1 -> DRAIN, drain counter=0.
- DRAIN: LAT cycles, oRD_VALID=0; on last: stage<A_BIT -> READ, stage+1, j=0; else -> IDLE, oDONE=1 for one cycle.
- Address rule, stage s, step j: stage 0: bias=j, coef=0. Stage s>=1: span=2^s, m=j mod span, block=j-m, bias=block+((span-m) mod span), coef=m<<(A_BIT-s). All arithmetic modulo 2^A_BIT, no overflow flag.
- Write path: LAT-deep shift register of {j, bias, rd_valid}; output tap drives oADDR_WR, oADDR_WR_BIAS and write strobe. Strobe goes to oWE_B when stage even (read A, write B), oWE_A when odd. Stage used for routing is the stage at read time (pipeline carries it).
- iSTALL=1: no state, counter or delay-line change; oRD_VALID, oWE_A, oWE_B forced 0; addresses hold.
- iABORT=1 (non-IDLE): next edge -> IDLE, delay line cleared, no oDONE. Priority: iRESET > iABORT > iSTALL > normal.
- iSTART while not IDLE: ignored. iSTART with iABORT same cycle in IDLE: start taken (abort no-op in IDLE).

## Timing
- Reset values: all addresses 0, oSTAGE=0, oST_ZERO=1, oST_LAST=0, oRD_VALID=0, oWE_A=oWE_B=0, oSOURCE_DATA=0, oRDY=1, oDONE=0.
- iSTART sampled at edge E0: from next cycle oRDY=0, oRD_VALID=1, oADDR_RD=0.
- Write for step j appears exactly LAT unstalled cycles after its read cycle; last write of a stage lands in the last DRAIN cycle.
- Stage length D+LAT cycles; transform length STAGES*(D+LAT) cycles plus stall cycles; oRDY=1 and oDONE=1 in the cycle after the final DRAIN cycle.
- Outputs all registered; no combinational input-to-output path except stall gating of oRD_VALID/oWE_*.

## Test plan
- A_BIT=3, LAT=2, single start, no stall -> 4 stages x 10 cycles; oRDY low 40 cycles, one oDONE; 8 oWE_B pulses in stages 0, 2, 8 oWE_A in stages 1, 3.
- Same run, address check -> stage 1 j=3: bias 3, j=2: bias 2; stage 2 j=5: bias 7, coef 2; stage 3 j=1: bias 7, coef 1; j=0: bias 0, coef 0.
- Write alignment -> every oWE cycle: {oADDR_WR, oADDR_WR_BIAS} equals the read pair from 2 unstalled cycles earlier; oSOURCE_DATA toggles per stage.
- iSTALL high 3 cycles at stage 1 j=4 -> addresses hold, no oRD_VALID/oWE, total length 43 cycles, sequences otherwise unchanged.
- iABORT at stage 2 j=6 -> IDLE next cycle, oRDY=1, no oDONE, no further oWE; subsequent iSTART gives full clean 40-cycle run.
- iRESET during DRAIN, and iSTART pulses while busy -> reset values next cycle; busy-time starts ignored (exactly one oDONE per accepted start).
